// File: rtl/debounce_pkg.sv
// Shared types and the round-robin index search for the button debounce front end.
// Channel indices are carried in EVT_ID_W bits, so up to MAX_BTN channels are supported.
package debounce_pkg;
  localparam int MAX_BTN  = 64;
  localparam int EVT_ID_W = 6;
  localparam int IDX_W    = EVT_ID_W + 1;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} arb_state_t;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic                press;
  } evt_t;

  typedef logic [IDX_W-1:0] idx_t;

  // First set bit of pend at or after ptr, wrapping modulo n; returns 0 when none is set.
  function automatic logic [EVT_ID_W-1:0] rr_pick(input logic [MAX_BTN-1:0]  pend,
                                                   input logic [EVT_ID_W-1:0] ptr,
                                                   input int                  n);
    logic                found;
    logic [EVT_ID_W-1:0] pick;
    idx_t                idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < MAX_BTN; k++) begin
      idx = {1'b0, ptr} + idx_t'(k);
      if (idx >= idx_t'(n)) idx = idx - idx_t'(n);
      if (k < n && !found && pend[idx[EVT_ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[EVT_ID_W-1:0];
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser and a tick-sampled stable counter.
// o_evt_stb pulses in the cycle the debounced level toggles; o_evt_press is the new level.
module debounce_chan #(
  parameter int STABLE_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_state,
  output logic o_evt_stb,
  output logic o_evt_press
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             w_diff;

  assign w_diff      = r_sync[1] ^ r_state;
  assign o_evt_stb   = i_tick && w_diff && (r_cnt == CNT_W'(STABLE_CNT - 1));
  assign o_evt_press = ~r_state;
  assign o_state     = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (i_tick) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (o_evt_stb) begin
          r_cnt   <= '0;
          r_state <= ~r_state;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/debounce_arbiter.sv
// Debounces N_BTN buttons on one shared sample tick and serialises press/release events round-robin;
// the event port holds its data while evt_ready is low. DEBOUNCE_ARB_OVF_EN adds sticky overwrite flags.
module debounce_arbiter #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn,
  output logic [N_BTN-1:0]         btn_state,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_press
`ifdef DEBOUNCE_ARB_OVF_EN
  ,
  output logic [N_BTN-1:0]         ovf_flag,
  input  logic                     ovf_clr
`endif
);
  import debounce_pkg::*;

  localparam int ID_W   = $clog2(N_BTN);
  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCNT_W-1:0]   r_tick_cnt;
  logic                w_tick;
  logic [N_BTN-1:0]    w_stb;
  logic [N_BTN-1:0]    w_press;
  logic [N_BTN-1:0]    w_clr;
  logic [N_BTN-1:0]    r_pend;
  logic [N_BTN-1:0]    r_pend_press;
  logic [MAX_BTN-1:0]  w_pend_ext;
  logic [EVT_ID_W-1:0] r_rr_ptr;
  logic [EVT_ID_W-1:0] w_pick;
  arb_state_t          r_state;
  evt_t                r_evt;
  logic                r_evt_vld;

  assign w_tick = (r_tick_cnt == TCNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_chan #(.STABLE_CNT(STABLE_CNT)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (btn[g]),
      .i_tick     (w_tick),
      .o_state    (btn_state[g]),
      .o_evt_stb  (w_stb[g]),
      .o_evt_press(w_press[g])
    );
  end

  always_comb begin
    w_pend_ext            = '0;
    w_pend_ext[N_BTN-1:0] = r_pend;
    w_pick                = rr_pick(w_pend_ext, r_rr_ptr, N_BTN);
    w_clr                 = '0;
    if (r_state == IDLE && |r_pend) w_clr[w_pick[ID_W-1:0]] = 1'b1;
  end

  // A fresh strobe beats the grant clear, so a same-cycle event on the granted channel stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_pend_press <= '0;
    end else begin
      r_pend       <= (r_pend & ~w_clr) | w_stb;
      r_pend_press <= (r_pend_press & ~w_stb) | (w_press & w_stb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_evt     <= '0;
      r_evt_vld <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pend) begin
            r_evt.id    <= w_pick;
            r_evt.press <= r_pend_press[w_pick[ID_W-1:0]];
            r_evt_vld   <= 1'b1;
            r_state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            r_evt_vld <= 1'b0;
            r_rr_ptr  <= (r_evt.id == EVT_ID_W'(N_BTN - 1)) ? '0 : r_evt.id + 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign evt_valid = r_evt_vld;
  assign evt_id    = r_evt.id[ID_W-1:0];
  assign evt_press = r_evt.press;

`ifdef DEBOUNCE_ARB_OVF_EN
  logic [N_BTN-1:0] r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= '0;
    else        r_ovf <= (ovf_clr ? '0 : r_ovf) | (w_stb & r_pend & ~w_clr);
  end

  assign ovf_flag = r_ovf;
`else
  // Without the flags an overwritten pending event is simply lost.
`endif
endmodule

// File: tb/tb_debounce_arbiter.sv
// Scoreboard bench for debounce_arbiter with N_BTN=4, TICK_DIV=4, STABLE_CNT=3.
// Expected events come from a batch model: which levels change, and in what round-robin order.
module tb_debounce_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_press;
`ifdef DEBOUNCE_ARB_OVF_EN
  logic [3:0] ovf_flag;
  logic       ovf_clr;
`endif

  always #5 clk = ~clk;

  debounce_arbiter #(.N_BTN(4), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_press(evt_press)
`ifdef DEBOUNCE_ARB_OVF_EN
    ,
    .ovf_flag (ovf_flag),
    .ovf_clr  (ovf_clr)
`endif
  );

  typedef struct {
    int id;
    bit press;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors  = 0;
  int         checks  = 0;
  int         hs_cnt  = 0;
  int         pushed  = 0;
  int         dropped = 0;
  logic [3:0] m_lvl   = '0;
  int         m_rr    = 0;
  bit         prev_hs = 0;
  bit         rnd_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per accepted event and checks the idle gap after it.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs = 0;
    end else begin
      if (prev_hs) chk("gap_after_accept", 32'(evt_valid), 32'd0);
      prev_hs = evt_valid && evt_ready;
      if (evt_valid && evt_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got id=%0d press=%0d, expected no event", evt_id, evt_press);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_id", 32'(evt_id), mon_e.id);
          chk("evt_press", 32'(evt_press), 32'(mon_e.press));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) evt_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Channels changing together are granted in scan order starting at the model's rr pointer.
  task automatic model_push(input logic [3:0] mask);
    logic [3:0] nl;
    int         j;
    int         last;
    nl   = m_lvl ^ mask;
    last = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (mask[j]) begin
        exp_q.push_back(exp_t'{id: j, press: nl[j]});
        pushed++;
        last = j;
      end
    end
    if (last >= 0) m_rr = (last + 1) % N;
    m_lvl = nl;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || evt_valid) && t < budget) begin
      cyc(1);
      t++;
    end
    chk("drain_in_time", 32'(t < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int t;
    t = 0;
    while (!evt_valid && t < budget) begin
      cyc(1);
      t++;
    end
    chk("valid_in_time", 32'(evt_valid), 32'd1);
  endtask

  // Glitches (1..8 clk) cover at most two samples, so they must never reach btn_state.
  task automatic do_batch(input logic [3:0] mask, input int glen);
    if (glen > 0) begin
      btn = btn ^ mask;
      cyc(glen);
      btn = btn ^ mask;
      cyc(12);
    end else begin
      model_push(mask);
      btn = btn ^ mask;
      cyc(16);
      wait_drain(400);
      cyc(2);
    end
    chk("btn_state_vs_model", 32'(btn_state), 32'(m_lvl));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    dropped += exp_q.size();
    exp_q.delete();
    m_lvl = '0;
    m_rr  = 0;
    repeat (5) begin
      btn = 4'($urandom);
      cyc(1);
    end
    chk("reset_btn_state", 32'(btn_state), 32'd0);
    chk("reset_evt_valid", 32'(evt_valid), 32'd0);
    btn = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   bad;
    int   hs_before;
    logic seen;
    logic [3:0] seen_any;
    logic [3:0] mask;

    rst_n     = 1'b0;
    btn       = 4'($urandom);
    evt_ready = 1'b1;
`ifdef DEBOUNCE_ARB_OVF_EN
    ovf_clr   = 1'b0;
`endif

    do_reset();
    cyc(100);
    chk("idle_no_events", hs_cnt, 32'd0);

    btn[0] = 1'b1;
    cyc(8);
    btn[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      seen |= btn_state[0];
    end
    chk("glitch_btn_state", 32'(seen), 32'd0);

    // Random bursts alternate with 4-cycle quiet windows, so no two samples in a row can differ.
    seen_any = '0;
    for (int c = 0; c < 100; c++) begin
      btn = ((c % 8) < 4) ? 4'($urandom) : 4'b0000;
      cyc(1);
      seen_any |= btn_state;
    end
    btn = '0;
    cyc(12);
    chk("noise_btn_state", 32'(seen_any), 32'd0);
    chk("noise_no_events", hs_cnt, 32'd0);

    model_push(4'b0010);
    btn[1] = 1'b1;
    n = 0;
    while (!btn_state[1] && n < 30) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n < 11 || n > 14) begin
      errors++;
      $display("FAIL press_latency: got %0d clk, expected 11..14", n);
    end
    cyc(40 - n);
    wait_drain(100);
    chk("btn1_pressed_state", 32'(btn_state), 32'(m_lvl));
    do_batch(4'b0010, 0);

    do_reset();
    do_batch(4'b1101, 0);
    do_batch(4'b0001, 0);

    rnd_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) do_batch(mask, $urandom_range(1, 8));
      else                           do_batch(mask, 0);
    end
    rnd_ready = 1'b0;
    evt_ready = 1'b1;
    cyc(4);

    do_reset();
    evt_ready = 1'b0;
    model_push(4'b0010);
    btn[1] = 1'b1;
    wait_valid(40);
    model_push(4'b0100);
    btn[2] = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(1);
      if (!(evt_valid === 1'b1 && evt_id === 2'd1 && evt_press === 1'b1)) bad++;
    end
    chk("hold_stable_violations", bad, 32'd0);
    chk("held_evt_id", 32'(evt_id), 32'd1);
    evt_ready = 1'b1;
    wait_drain(100);
    chk("backpressure_state", 32'(btn_state), 32'(m_lvl));

`ifdef DEBOUNCE_ARB_OVF_EN
    evt_ready = 1'b0;
    model_push(4'b0001);
    btn[0] = 1'b1;
    wait_valid(40);
    btn[3] = 1'b1;
    cyc(20);
    btn[3] = 1'b0;
    cyc(20);
    chk("ovf_flag_set", 32'(ovf_flag[3]), 32'd1);
    exp_q.push_back(exp_t'{id: 3, press: 1'b0});
    pushed++;
    m_rr = 0;
    evt_ready = 1'b1;
    wait_drain(100);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_flag_clr", 32'(ovf_flag), 32'd0);
`endif

    evt_ready = 1'b0;
    model_push(4'b1000);
    btn[3] = 1'b1;
    wait_valid(40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_evt_valid", 32'(evt_valid), 32'd0);
    dropped += exp_q.size();
    exp_q.delete();
    btn   = '0;
    m_lvl = '0;
    m_rr  = 0;
    hs_before = hs_cnt;
    cyc(3);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    cyc(100);
    chk("no_stale_event", hs_cnt - hs_before, 32'd0);
    chk("post_reset_state", 32'(btn_state), 32'd0);

    chk("handshakes_vs_expected", hs_cnt, pushed - dropped);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
